// File: rtl/mem_stage_if.sv
// mem_stage_if: CPU bus between the memory stage (master) and the bus arbiter/slave
interface mem_stage_if #(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32
);
    logic                   bus_req;
    logic                   bus_grnt;
    logic                   bus_as;
    logic                   bus_rw;
    logic [WORD_ADDR_W-1:0] bus_addr;
    logic [WORD_DATA_W-1:0] bus_wr_data;
    logic [WORD_DATA_W-1:0] bus_rd_data;
    logic                   bus_rdy;

    modport master(
        output bus_req, bus_as, bus_rw, bus_addr, bus_wr_data,
        input  bus_grnt, bus_rd_data, bus_rdy
    );

    modport slave(
        input  bus_req, bus_as, bus_rw, bus_addr, bus_wr_data,
        output bus_grnt, bus_rd_data, bus_rdy
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage - word load/store bus master, misalignment check, MEM register
module mem_stage #(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   busy,
    input  logic [WORD_ADDR_W-1:0] ex_pc,
    input  logic                   ex_en,
    input  logic                   ex_br_flag,
    input  logic [1:0]             ex_mem_op,
    input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
    input  logic [1:0]             ex_ctrl_op,
    input  logic [REG_ADDR_W-1:0]  ex_dst_addr,
    input  logic                   ex_gpr_we_,
    input  logic [2:0]             ex_exp_code,
    input  logic [WORD_DATA_W-1:0] ex_out,
    mem_stage_if.master            bus,
    output logic [WORD_ADDR_W-1:0] mem_pc,
    output logic                   mem_en,
    output logic                   mem_br_flag,
    output logic [1:0]             mem_ctrl_op,
    output logic [REG_ADDR_W-1:0]  mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic [2:0]             mem_exp_code,
    output logic [WORD_DATA_W-1:0] mem_out
);
    localparam logic [1:0] OP_LDW       = 2'd1;
    localparam logic [1:0] OP_STW       = 2'd2;
    localparam logic [2:0] EXP_MISALIGN = 3'd4;

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, DONE} state_t;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br;
        logic [1:0]             ctrl;
        logic [REG_ADDR_W-1:0]  dst;
        logic                   we_;
        logic [2:0]             exp;
        logic [WORD_DATA_W-1:0] out;
    } mreg_t;

    localparam mreg_t MREG_RST = '{pc: '0, en: 1'b0, br: 1'b0, ctrl: '0, dst: '0,
                                   we_: 1'b1, exp: '0, out: '0};

    state_t                 state_q;
    logic                   flush_pend_q;
    logic                   req_q;
    logic                   as_q;
    logic                   rw_q;
    logic [WORD_ADDR_W-1:0] addr_q;
    logic [WORD_DATA_W-1:0] wr_data_q;
    logic [WORD_DATA_W-1:0] rd_buf_q;
    logic [WORD_DATA_W-1:0] rd_word;
    mreg_t                  mreg_q;
    mreg_t                  mreg_d;
    logic                   mem_acc;
    logic                   acc;
    logic                   mis;
    logic                   xfer;
    logic                   kill;

    // An exception already raised upstream suppresses the access entirely
    assign mem_acc = ex_en && (ex_mem_op == OP_LDW || ex_mem_op == OP_STW) && ex_exp_code == 3'd0;
    assign acc     = mem_acc && ex_out[1:0] == 2'b00;
    assign mis     = mem_acc && ex_out[1:0] != 2'b00;
    assign xfer    = state_q == ACCESS || state_q == DONE;
    assign kill    = flush || (xfer && flush_pend_q);
    assign rd_word = state_q == DONE ? rd_buf_q : bus.bus_rd_data;

    // Stall the pipeline from the cycle an access is seen until bus_rdy arrives
    always_comb busy = state_q == IDLE   ? acc && !flush :
                       state_q == REQ    ? 1'b1 :
                       state_q == ACCESS ? !bus.bus_rdy : 1'b0;

    // Next MEM register: held under stall, else flush > misalign > finished access / pass-through
    always_comb begin
        mreg_d = mreg_q;
        if (!stall)
            mreg_d = kill ? MREG_RST : '{
                pc:   ex_pc,
                en:   ex_en,
                br:   ex_br_flag,
                ctrl: mis ? 2'd0 : ex_ctrl_op,
                dst:  mis ? {REG_ADDR_W{1'b0}} : ex_dst_addr,
                we_:  mis | ex_gpr_we_,
                exp:  mis ? EXP_MISALIGN : ex_exp_code,
                out:  xfer ? (ex_mem_op == OP_LDW ? rd_word : {WORD_DATA_W{1'b0}}) :
                      mis ? {WORD_DATA_W{1'b0}} : ex_out
            };
    end

    // Bus master FSM with registered bus outputs; a started transfer always runs to bus_rdy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            req_q        <= 1'b0;
            as_q         <= 1'b0;
            rw_q         <= 1'b1;
            addr_q       <= '0;
            wr_data_q    <= '0;
            rd_buf_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (acc && !flush) begin
                    state_q   <= REQ;
                    req_q     <= 1'b1;
                    addr_q    <= ex_out[WORD_ADDR_W+1:2];
                    rw_q      <= ex_mem_op == OP_LDW;
                    wr_data_q <= ex_mem_wr_data;
                end
                REQ: if (flush) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end else if (bus.bus_grnt) begin
                    state_q <= ACCESS;
                    as_q    <= 1'b1;
                end
                ACCESS: begin
                    if (flush)
                        flush_pend_q <= 1'b1;
                    if (bus.bus_rdy) begin
                        req_q    <= 1'b0;
                        as_q     <= 1'b0;
                        rd_buf_q <= bus.bus_rd_data;
                        state_q  <= stall ? DONE : IDLE;
                        if (!stall)
                            flush_pend_q <= 1'b0;
                    end
                end
                DONE: if (!stall || flush) begin
                    state_q      <= IDLE;
                    flush_pend_q <= 1'b0;
                end
            endcase
        end
    end

    // MEM pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mreg_q <= MREG_RST;
        else
            mreg_q <= mreg_d;
    end

    assign {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out} = mreg_q;

    assign bus.bus_req     = req_q;
    assign bus.bus_as      = as_q;
    assign bus.bus_rw      = rw_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_wr_data = wr_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with a bus slave and reference model
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ext_stall;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] ex_pc;
    logic        ex_en;
    logic        ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;
    logic [29:0] mem_pc;
    logic        mem_en;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic [74:0] mem_vec;
    logic [31:0] slv_mem [0:255];
    logic [31:0] ref_mem [0:255];
    int          total = 0;
    int          bad = 0;

    localparam logic [74:0] RST_VEC = {30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0};

    mem_stage_if bif();

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .bus(bif),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    assign stall   = ext_stall | busy;
    assign mem_vec = {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ex(input logic [29:0] pc, input logic en, input logic [1:0] op, input logic [4:0] dst,
                          input logic we_n, input logic [2:0] exp, input logic [31:0] a, input logic [31:0] wd);
        ex_pc = pc; ex_en = en; ex_br_flag = pc[0]; ex_mem_op = op; ex_ctrl_op = pc[2:1];
        ex_dst_addr = dst; ex_gpr_we_ = we_n; ex_exp_code = exp; ex_out = a; ex_mem_wr_data = wd;
    endtask

    function automatic bit is_acc();
        return ex_en && (ex_mem_op == 2'd1 || ex_mem_op == 2'd2) && ex_exp_code == 3'd0 && ex_out[1:0] == 2'b00;
    endfunction

    // What the MEM register must hold once the instruction currently in EX retires
    function automatic logic [74:0] expect_vec(input logic [31:0] ld);
        bit memop = ex_en && (ex_mem_op == 2'd1 || ex_mem_op == 2'd2) && ex_exp_code == 3'd0;
        if (memop && ex_out[1:0] != 2'b00)
            return {ex_pc, ex_en, ex_br_flag, 2'd0, 5'd0, 1'b1, 3'd4, 32'd0};
        if (memop)
            return {ex_pc, ex_en, ex_br_flag, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, 3'd0, ex_mem_op == 2'd1 ? ld : 32'd0};
        return {ex_pc, ex_en, ex_br_flag, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out};
    endfunction

    // Runs the instruction in EX to retirement, acting as bus slave; entered and left at a negedge
    task automatic exec(input int gl, input int rl, input int hold, output int bcnt, output int reqs,
                        output int chg, output logic [29:0] a_s, output logic rw_s, output logic [31:0] wd_s,
                        output bit to);
        int gw = gl;
        int rw = rl;
        int h = 0;
        int cyc = 0;
        bit rdy_seen = 0;
        bit retired = 0;
        logic prev = 1'b0;
        logic [74:0] snap = mem_vec;
        bcnt = 0; reqs = 0; chg = 0; to = 0; a_s = '0; rw_s = 1'b1; wd_s = '0;
        while (!retired) begin
            if (bif.bus_req && !prev) reqs++;
            prev = bif.bus_req;
            if (mem_vec !== snap) chg++;
            bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b0; ext_stall = 1'b0;
            if (bif.bus_req && !bif.bus_as) begin
                if (gw == 0) bif.bus_grnt = 1'b1; else gw--;
            end
            if (bif.bus_as) begin
                if (rw == 0) begin
                    bif.bus_rdy = 1'b1; rdy_seen = 1;
                    a_s = bif.bus_addr; rw_s = bif.bus_rw; wd_s = bif.bus_wr_data;
                    if (bif.bus_rw) bif.bus_rd_data = slv_mem[bif.bus_addr[7:0]];
                    else begin slv_mem[bif.bus_addr[7:0]] = bif.bus_wr_data; bif.bus_rd_data = $urandom; end
                end else rw--;
            end
            if (rdy_seen && h < hold) begin ext_stall = 1'b1; h++; end
            #1;
            if (busy) bcnt++;
            if (!stall) retired = 1;
            @(negedge clk);
            if (++cyc > 300) begin to = 1; retired = 1; end
        end
        bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b0; ext_stall = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++; if (mem_vec !== RST_VEC) begin bad++; $display("FAIL rst_mem: got %h want %h", mem_vec, RST_VEC); end
        total++; if ({bif.bus_req, bif.bus_as, bif.bus_rw} !== 3'b001) begin bad++; $display("FAIL rst_bus_ctl: got %b want 001", {bif.bus_req, bif.bus_as, bif.bus_rw}); end
        total++; if ({bif.bus_addr, bif.bus_wr_data} !== 62'd0) begin bad++; $display("FAIL rst_bus_data: got %h want 0", {bif.bus_addr, bif.bus_wr_data}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        int bc, rq, ch; logic [29:0] a; logic r; logic [31:0] w; bit to; logic [74:0] ev;
        set_ex(30'h100, 1'b1, 2'd0, 5'd3, 1'b0, 3'd0, 32'h1234_5678, 32'h0);
        ev = expect_vec(32'h0);
        exec(0, 0, 0, bc, rq, ch, a, r, w, to);
        total++; if (mem_out !== 32'h1234_5678) begin bad++; $display("FAIL alu_out: got %h want 12345678", mem_out); end
        total++; if (mem_vec !== ev) begin bad++; $display("FAIL alu_reg: got %h want %h", mem_vec, ev); end
        total++; if (bc !== 0 || rq !== 0) begin bad++; $display("FAIL alu_nobus: busy=%0d req=%0d want 0 0", bc, rq); end
    endtask

    task automatic test_load();
        int bc, rq, ch; logic [29:0] a; logic r; logic [31:0] w; bit to;
        slv_mem[8'h40] = 32'hDEAD_BEEF; ref_mem[8'h40] = 32'hDEAD_BEEF;
        set_ex(30'h104, 1'b1, 2'd1, 5'd7, 1'b0, 3'd0, 32'h0000_0100, 32'h0);
        exec(0, 0, 0, bc, rq, ch, a, r, w, to);
        total++; if (a !== 30'h40 || r !== 1'b1) begin bad++; $display("FAIL ld_addr_rw: got %h %b want 40 1", a, r); end
        total++; if (bc !== 2) begin bad++; $display("FAIL ld_busy: got %0d want 2", bc); end
        total++; if (mem_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_out: got %h want deadbeef", mem_out); end
        total++; if (mem_gpr_we_ !== 1'b0 || mem_dst_addr !== 5'd7) begin bad++; $display("FAIL ld_we: got %b %0d want 0 7", mem_gpr_we_, mem_dst_addr); end
        total++; if (rq !== 1 || to) begin bad++; $display("FAIL ld_req: got %0d to=%0d want 1 0", rq, to); end
    endtask

    task automatic test_misalign();
        int bc, rq, ch; logic [29:0] a; logic r; logic [31:0] w; bit to;
        set_ex(30'h108, 1'b1, 2'd2, 5'd9, 1'b0, 3'd0, 32'h0000_0202, 32'h1111_1111);
        exec(0, 0, 0, bc, rq, ch, a, r, w, to);
        total++; if (rq !== 0 || bc !== 0) begin bad++; $display("FAIL mis_nobus: req=%0d busy=%0d want 0 0", rq, bc); end
        total++; if ({mem_exp_code, mem_gpr_we_, mem_out} !== {3'd4, 1'b1, 32'd0}) begin bad++; $display("FAIL mis_reg: got %h want %h", {mem_exp_code, mem_gpr_we_, mem_out}, {3'd4, 1'b1, 32'd0}); end
        total++; if ({mem_pc, mem_en, mem_ctrl_op, mem_dst_addr} !== {30'h108, 1'b1, 2'd0, 5'd0}) begin bad++; $display("FAIL mis_pass: got %h", {mem_pc, mem_en, mem_ctrl_op, mem_dst_addr}); end
    endtask

    task automatic test_store_stall();
        int bc, rq, ch; logic [29:0] a; logic r; logic [31:0] w; bit to; logic [74:0] ev;
        set_ex(30'h10c, 1'b1, 2'd2, 5'd0, 1'b1, 3'd0, 32'h0000_0010, 32'hA5A5_A5A5);
        ev = expect_vec(32'h0);
        ref_mem[4] = 32'hA5A5_A5A5;
        exec(0, 0, 2, bc, rq, ch, a, r, w, to);
        total++; if (w !== 32'hA5A5_A5A5 || r !== 1'b0 || a !== 30'h4) begin bad++; $display("FAIL st_bus: got %h %b %h want a5a5a5a5 0 4", w, r, a); end
        total++; if (ch !== 0) begin bad++; $display("FAIL st_hold: register changed %0d times under stall, want 0", ch); end
        total++; if (mem_vec !== ev) begin bad++; $display("FAIL st_reg: got %h want %h", mem_vec, ev); end
        total++; if (slv_mem[4] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL st_mem: got %h want a5a5a5a5", slv_mem[4]); end
        set_ex(30'h110, 1'b1, 2'd0, 5'd1, 1'b0, 3'd0, 32'h0, 32'h0);
        exec(0, 0, 0, bc, rq, ch, a, r, w, to);
        total++; if (rq !== 0 || bif.bus_req !== 1'b0) begin bad++; $display("FAIL st_noreq2: got %0d %b want 0 0", rq, bif.bus_req); end
    endtask

    task automatic test_flush_req();
        int bc, rq, ch; logic [29:0] a; logic r; logic [31:0] w; bit to;
        set_ex(30'h114, 1'b1, 2'd0, 5'd2, 1'b0, 3'd0, 32'h55, 32'h0);
        exec(0, 0, 0, bc, rq, ch, a, r, w, to);
        set_ex(30'h118, 1'b1, 2'd1, 5'd4, 1'b0, 3'd0, 32'h20, 32'h0);
        @(negedge clk);
        total++; if (bif.bus_req !== 1'b1) begin bad++; $display("FAIL fr_req: got %b want 1", bif.bus_req); end
        flush = 1'b1;
        @(negedge clk);
        total++; if (bif.bus_req !== 1'b0) begin bad++; $display("FAIL fr_drop: got %b want 0", bif.bus_req); end
        @(negedge clk);
        total++; if (mem_vec !== RST_VEC) begin bad++; $display("FAIL fr_reg: got %h want %h", mem_vec, RST_VEC); end
        total++; if (bif.bus_req !== 1'b0) begin bad++; $display("FAIL fr_noreq: got %b want 0", bif.bus_req); end
        flush = 1'b0;
        set_ex(30'h11c, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic test_flush_access();
        int bc, rq, ch; logic [29:0] a; logic r; logic [31:0] w; bit to;
        set_ex(30'h120, 1'b1, 2'd0, 5'd2, 1'b0, 3'd0, 32'h66, 32'h0);
        exec(0, 0, 0, bc, rq, ch, a, r, w, to);
        set_ex(30'h124, 1'b1, 2'd1, 5'd5, 1'b0, 3'd0, 32'h24, 32'h0);
        @(negedge clk);
        bif.bus_grnt = 1'b1;
        @(negedge clk);
        bif.bus_grnt = 1'b0;
        total++; if (bif.bus_as !== 1'b1) begin bad++; $display("FAIL fa_as: got %b want 1", bif.bus_as); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; bif.bus_rdy = 1'b1; bif.bus_rd_data = 32'h1111_2222;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fa_busy: got %b want 0", busy); end
        @(negedge clk);
        bif.bus_rdy = 1'b0;
        total++; if ({mem_en, mem_gpr_we_, mem_out} !== {1'b0, 1'b1, 32'd0}) begin bad++; $display("FAIL fa_reg: got %h want %h", {mem_en, mem_gpr_we_, mem_out}, {1'b0, 1'b1, 32'd0}); end
        total++; if ({bif.bus_req, bif.bus_as} !== 2'b00) begin bad++; $display("FAIL fa_bus: got %b want 00", {bif.bus_req, bif.bus_as}); end
        set_ex(30'h128, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        int bc, rq, ch; logic [29:0] a; logic r; logic [31:0] w; bit to; logic [74:0] ev;
        set_ex(30'h12c, 1'b1, 2'd0, 5'd6, 1'b0, 3'd0, 32'h77, 32'h0);
        exec(0, 0, 0, bc, rq, ch, a, r, w, to);
        set_ex(30'h130, 1'b1, 2'd2, 5'd0, 1'b1, 3'd0, 32'h30, 32'hCAFE_0001);
        @(negedge clk);
        bif.bus_grnt = 1'b1;
        @(negedge clk);
        bif.bus_grnt = 1'b0;
        total++; if (bif.bus_as !== 1'b1) begin bad++; $display("FAIL rm_as: got %b want 1", bif.bus_as); end
        #2 reset = 1'b1;
        #1;
        total++; if ({bif.bus_req, bif.bus_as, bif.bus_rw, bif.bus_addr, bif.bus_wr_data} !== {3'b001, 62'd0}) begin bad++; $display("FAIL rm_bus: got %h", {bif.bus_req, bif.bus_as, bif.bus_rw, bif.bus_addr, bif.bus_wr_data}); end
        total++; if (mem_vec !== RST_VEC) begin bad++; $display("FAIL rm_reg: got %h want %h", mem_vec, RST_VEC); end
        @(negedge clk);
        reset = 1'b0;
        set_ex(30'h134, 1'b1, 2'd1, 5'd8, 1'b0, 3'd0, 32'h0000_0100, 32'h0);
        ev = expect_vec(ref_mem[8'h40]);
        exec(0, 0, 0, bc, rq, ch, a, r, w, to);
        total++; if (bc !== 2 || mem_vec !== ev) begin bad++; $display("FAIL rm_idle: busy=%0d reg=%h want 2 %h", bc, mem_vec, ev); end
    endtask

    task automatic test_random();
        int bc, rq, ch, gl, rl, hd, nbad; logic [29:0] a; logic r; logic [31:0] w; bit to, acc; logic [74:0] ev; logic [31:0] ad;
        for (int i = 0; i < 60; i++) begin
            ad = $urandom;
            if ($urandom_range(0, 2) != 0) ad[1:0] = 2'b00;
            set_ex(30'($urandom), $urandom_range(0, 7) != 0, 2'($urandom), 5'($urandom), 1'($urandom),
                   $urandom_range(0, 3) == 0 ? 3'($urandom_range(1, 4)) : 3'd0, ad, $urandom);
            gl = $urandom_range(0, 3); rl = $urandom_range(0, 3); hd = $urandom_range(0, 2);
            acc = is_acc();
            ev = expect_vec(ref_mem[ad[9:2]]);
            if (acc && ex_mem_op == 2'd2) ref_mem[ad[9:2]] = ex_mem_wr_data;
            exec(gl, rl, hd, bc, rq, ch, a, r, w, to);
            total++; if (mem_vec !== ev) begin bad++; $display("FAIL rnd_reg[%0d]: got %h want %h", i, mem_vec, ev); end
            total++; if (bc !== (acc ? 2 + gl + rl : 0)) begin bad++; $display("FAIL rnd_busy[%0d]: got %0d want %0d", i, bc, acc ? 2 + gl + rl : 0); end
            total++; if (rq !== (acc ? 1 : 0) || ch !== 0 || to) begin bad++; $display("FAIL rnd_bus[%0d]: req=%0d chg=%0d to=%0d want %0d 0 0", i, rq, ch, to, acc ? 1 : 0); end
        end
        nbad = 0;
        for (int i = 0; i < 256; i++) if (slv_mem[i] !== ref_mem[i]) nbad++;
        total++; if (nbad !== 0) begin bad++; $display("FAIL rnd_mem: %0d words differ, want 0", nbad); end
    endtask

    initial begin
        reset = 1'b1; ext_stall = 1'b0; flush = 1'b0;
        bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b0; bif.bus_rd_data = '0;
        set_ex(30'h0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) begin slv_mem[i] = $urandom; ref_mem[i] = slv_mem[i]; end
        test_reset();
        test_alu();
        test_load();
        test_misalign();
        test_store_stall();
        test_flush_req();
        test_flush_access();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
